// File: rtl/rvv_pipe_slice.sv
// Valid/ready register slice with a skid entry for the RVV datapath.
// Registered in_ready and out_valid; synchronous flush kills held entries.
module rvv_pipe_slice #(
  parameter int unsigned          WIDTH = 32,
  parameter logic [WIDTH-1:0]     INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic             main_v;
  logic             skid_v;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_d;

  logic             in_fire;
  logic             out_fire;
  logic             main_v_n;
  logic             skid_v_n;
  logic             main_ld_in;
  logic             main_ld_skid;
  logic             skid_ld;

  assign in_ready  = ~skid_v;
  assign out_valid = main_v;
  assign out_data  = main_d;
  assign count     = {1'b0, main_v} + {1'b0, skid_v};

  // out_fire is gated by main_v so an unknown out_ready
  // while empty never reaches the state update.
  assign in_fire  = in_valid & ~skid_v;
  assign out_fire = main_v & out_ready;

  always_comb begin
    main_v_n     = main_v;
    skid_v_n     = skid_v;
    main_ld_in   = 1'b0;
    main_ld_skid = 1'b0;
    skid_ld      = 1'b0;
    unique case (1'b1)
      ~main_v: begin
        main_v_n   = in_fire;
        main_ld_in = in_fire;
      end
      main_v & ~skid_v: begin
        main_ld_in = in_fire & out_fire;
        skid_ld    = in_fire & ~out_fire;
        main_v_n   = in_fire | ~out_fire;
        skid_v_n   = in_fire & ~out_fire;
      end
      default: begin
        main_ld_skid = out_fire;
        skid_v_n     = ~out_fire;
      end
    endcase
    // Flush drops both entries; data registers keep their contents.
    if (flush) begin
      main_v_n     = 1'b0;
      skid_v_n     = 1'b0;
      main_ld_in   = 1'b0;
      main_ld_skid = 1'b0;
      skid_ld      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= INIT;
      skid_d <= INIT;
    end else begin
      main_v <= main_v_n;
      skid_v <= skid_v_n;
      if (main_ld_in)
        main_d <= in_data;
      else if (main_ld_skid)
        main_d <= skid_d;
      if (skid_ld)
        skid_d <= in_data;
    end
  end

  a_skid_needs_main: assert property (
    @(posedge clk) disable iff (rst) skid_v |-> main_v
  );

  a_count_range: assert property (
    @(posedge clk) disable iff (rst) count != 2'd3
  );

endmodule

// File: tb/tb_rvv_pipe_slice.sv
// Bench for rvv_pipe_slice: directed scenarios plus random traffic
// against a queue-based FIFO reference model.
module tb_rvv_pipe_slice;

  localparam int unsigned W = 32;
  localparam logic [W-1:0] INIT_V = 32'hC0DE_0001;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   count;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] q[$];

  rvv_pipe_slice #(.WIDTH(W), .INIT(INIT_V)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic step(input bit r, input bit f, input bit iv,
                      input logic [W-1:0] id, input logic ordy);
    bit ifire;
    bit ofire;
    rst       = r;
    flush     = f;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    ifire = iv && (q.size() < 2);
    ofire = (q.size() > 0) && (ordy === 1'b1);
    @(posedge clk);
    if (r || f) begin
      q.delete();
    end else begin
      if (ofire) void'(q.pop_front());
      if (ifire) q.push_back(id);
    end
    #1;
    check("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
    check("in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
    check("count", {30'b0, count}, 32'(q.size()));
    if (q.size() > 0)
      check("out_data", out_data, q[0]);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;

    // Reset held two cycles with traffic offered.
    step(1, 0, 1, 32'hDEAD, 0);
    step(1, 0, 1, 32'hDEAD, 0);
    check("rst_out_data", out_data, INIT_V);
    check("rst_count", {30'b0, count}, 32'd0);
    step(0, 0, 0, 32'h0, 1'bx);
    check("rst_release_valid", {31'b0, out_valid}, 32'd0);
    check("rst_release_data", out_data, INIT_V);

    // Streaming at full rate.
    step(0, 0, 1, 32'h1, 1);
    check("stream1", out_data, 32'h1);
    step(0, 0, 1, 32'h2, 1);
    check("stream2", out_data, 32'h2);
    step(0, 0, 1, 32'h3, 1);
    check("stream3", out_data, 32'h3);
    check("stream_count", {30'b0, count}, 32'd1);
    step(0, 0, 0, 32'h0, 1);

    // Backpressure into the skid entry.
    step(0, 0, 1, 32'hA, 0);
    step(0, 0, 1, 32'hB, 0);
    check("bp_count2", {30'b0, count}, 32'd2);
    check("bp_ready0", {31'b0, in_ready}, 32'd0);
    step(0, 0, 1, 32'hC, 0);
    check("bp_hold_a", out_data, 32'hA);
    step(0, 0, 1, 32'hC, 1);
    check("bp_out_b", out_data, 32'hB);
    check("bp_count1a", {30'b0, count}, 32'd1);
    step(0, 0, 1, 32'hC, 1);
    check("bp_out_c", out_data, 32'hC);
    check("bp_count1b", {30'b0, count}, 32'd1);
    step(0, 0, 0, 32'h0, 1);
    check("bp_count0", {30'b0, count}, 32'd0);

    // Simultaneous in/out while ONE.
    step(0, 0, 1, 32'h5, 0);
    step(0, 0, 1, 32'h6, 1);
    check("sim_data", out_data, 32'h6);
    check("sim_count", {30'b0, count}, 32'd1);
    check("sim_noskid", {31'b0, in_ready}, 32'd1);
    step(0, 0, 0, 32'h0, 1);

    // Flush from FULL discards the concurrent push.
    step(0, 0, 1, 32'h10, 0);
    step(0, 0, 1, 32'h11, 0);
    step(0, 1, 1, 32'h12, 0);
    check("flush_valid", {31'b0, out_valid}, 32'd0);
    check("flush_count", {30'b0, count}, 32'd0);
    check("flush_ready", {31'b0, in_ready}, 32'd1);
    step(0, 0, 0, 32'h0, 1);
    check("flush_no12", {31'b0, out_valid}, 32'd0);

    // Reset mid-operation from FULL.
    step(0, 0, 1, 32'h20, 0);
    step(0, 0, 1, 32'h21, 0);
    step(1, 0, 0, 32'h0, 1);
    check("rstmid_count", {30'b0, count}, 32'd0);
    check("rstmid_data", out_data, INIT_V);
    step(0, 0, 1, 32'h7, 0);
    check("rstmid_push", out_data, 32'h7);
    check("rstmid_valid", {31'b0, out_valid}, 32'd1);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      bit r;
      bit f;
      r = ($urandom_range(0, 199) == 0);
      f = ($urandom_range(0, 39) == 0);
      step(r, f, $urandom_range(0, 3) != 0, $urandom,
           $urandom_range(0, 2) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
